// File: rtl/poliriscv_mc_ctrl.sv
// rtl/poliriscv_mc_ctrl.sv - multi-cycle control FSM sequencing the poliriscv datapath over a shared memory port
// Optional counters (cycle_cnt, instret_cnt) are enabled by POLIRISCV_MC_PERFCNT_EN.
module poliriscv_mc_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic        pc_src,
    output logic        rf_we,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  wb_sel,
    output logic [3:0]  state,
`ifdef POLIRISCV_MC_PERFCNT_EN
    output logic [31:0] cycle_cnt,
    output logic [31:0] instret_cnt,
`endif
    output logic        halted
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_HALT     = 4'd15
    } state_t;

    state_t     r_state;
    state_t     w_next;
    logic       w_req, w_we, w_ir, w_pcw, w_pcs, w_rfw, w_taken;
    logic [1:0] w_a, w_b, w_op, w_wb;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_req   = 1'b0;
        w_we    = 1'b0;
        w_ir    = 1'b0;
        w_pcw   = 1'b0;
        w_pcs   = 1'b0;
        w_rfw   = 1'b0;
        w_taken = 1'b0;
        w_a     = 2'b00;
        w_b     = 2'b00;
        w_op    = 2'b00;
        w_wb    = 2'b00;
        case (r_state)
            S_FETCH: begin
                w_req = 1'b1;
                w_b   = 2'b01;
                if (mem_ready) begin
                    w_ir   = 1'b1;
                    w_pcw  = 1'b1;
                    w_next = S_DECODE;
                end
            end
            S_DECODE: begin
                // old PC + immediate lands in ALUOut for branch/JAL targets
                w_a = 2'b01;
                w_b = 2'b10;
                case (opcode)
                    7'b0110011:             w_next = S_EXEC_R;
                    7'b0010011:             w_next = S_EXEC_I;
                    7'b0000011, 7'b0100011: w_next = S_MEM_ADDR;
                    7'b1100011:             w_next = S_BRANCH;
                    7'b1101111:             w_next = S_JAL;
                    default:                w_next = S_HALT;
                endcase
            end
            S_EXEC_R: begin
                w_a    = 2'b10;
                w_op   = 2'b10;
                w_next = S_WB_ALU;
            end
            S_EXEC_I: begin
                w_a    = 2'b10;
                w_b    = 2'b10;
                w_op   = 2'b10;
                w_next = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                w_a    = 2'b10;
                w_b    = 2'b10;
                w_next = (opcode == 7'b0000011) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_req = 1'b1;
                if (mem_ready) begin
                    w_next = S_WB_MEM;
                end
            end
            S_MEM_WR: begin
                w_req = 1'b1;
                w_we  = 1'b1;
                if (mem_ready) begin
                    w_next = S_FETCH;
                end
            end
            S_WB_ALU: begin
                w_rfw  = 1'b1;
                w_next = S_FETCH;
            end
            S_WB_MEM: begin
                w_rfw  = 1'b1;
                w_wb   = 2'b01;
                w_next = S_FETCH;
            end
            S_BRANCH: begin
                w_a    = 2'b10;
                w_op   = 2'b01;
                w_next = S_FETCH;
                case (funct3)
                    3'b000:  w_taken = zero;
                    3'b001:  w_taken = ~zero;
                    default: w_next  = S_HALT;
                endcase
                w_pcw = w_taken;
                w_pcs = w_taken;
            end
            S_JAL: begin
                w_rfw  = 1'b1;
                w_wb   = 2'b10;
                w_pcw  = 1'b1;
                w_pcs  = 1'b1;
                w_next = S_FETCH;
            end
            S_HALT: begin
                w_next = S_HALT;
            end
            default: begin
                w_next = S_HALT;
            end
        endcase
    end

    // outputs are forced low while reset is held, independent of the clock
    assign mem_req   = rst & w_req;
    assign mem_we    = rst & w_we;
    assign ir_we     = rst & w_ir;
    assign pc_we     = rst & w_pcw;
    assign pc_src    = rst & w_pcs;
    assign rf_we     = rst & w_rfw;
    assign alu_src_a = rst ? w_a  : 2'b00;
    assign alu_src_b = rst ? w_b  : 2'b00;
    assign alu_op    = rst ? w_op : 2'b00;
    assign wb_sel    = rst ? w_wb : 2'b00;
    assign state     = r_state;
    assign halted    = rst & (r_state == S_HALT);

`ifdef POLIRISCV_MC_PERFCNT_EN
    logic [31:0] r_cycle_cnt;
    logic [31:0] r_instret_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cycle_cnt   <= 32'd0;
            r_instret_cnt <= 32'd0;
        end else begin
            if (r_state != S_HALT) begin
                r_cycle_cnt <= r_cycle_cnt + 32'd1;
            end
            if ((w_next == S_FETCH) && (r_state != S_FETCH)) begin
                r_instret_cnt <= r_instret_cnt + 32'd1;
            end
        end
    end

    assign cycle_cnt   = r_cycle_cnt;
    assign instret_cnt = r_instret_cnt;
`endif

endmodule

// File: doc/poliriscv_mc_ctrl.md
# poliriscv_mc_ctrl

Multi-cycle control unit that sequences the poliriscv datapath one instruction at a time over a shared, variable-latency memory port. It replaces the single-cycle combinational decode with a registered state machine that drives the datapath's register-write, PC-write, instruction-register and memory enables, along with its mux selects. It sits between the datapath (opcode, funct3, ALU zero) and the unified memory (req/ready handshake).

## Interface
- No parameters; encodings are fixed below.
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- opcode  in  7  instruction register bits [6:0].
- funct3  in  3  instruction register bits [14:12].
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request; held high until mem_ready.
- mem_we  out  1  write request, valid with mem_req.
- ir_we  out  1  instruction register load.
- pc_we  out  1  PC load.
- pc_src  out  1  0 = ALU result, 1 = ALUOut register.
- rf_we  out  1  register file write.
- alu_src_a  out  2  00 = PC, 01 = old PC, 10 = rs1.
- alu_src_b  out  2  00 = rs2, 01 = constant 4, 10 = immediate.
- alu_op  out  2  00 = add, 01 = sub, 10 = decode funct3/funct7.
- wb_sel  out  2  00 = ALUOut, 01 = memory data, 10 = PC.
- state  out  4  current state, for debug.
- halted  out  1  high in HALT.

## Operation
- State encodings: FETCH=0, DECODE=1, EXEC_R=2, EXEC_I=3, MEM_ADDR=4, MEM_RD=5, MEM_WR=6, WB_ALU=7, WB_MEM=8, BRANCH=9, JAL=10, HALT=15. Codes 11–14 are unreachable and go to HALT.
- Unlisted outputs are 0 in every state.
- FETCH:
  - mem_req=1, alu_src_a=00, alu_src_b=01, alu_op=00.
  - On mem_ready: ir_we=1, pc_we=1, pc_src=0, then go to DECODE. Otherwise stay in FETCH.
- DECODE: alu_src_a=01, alu_src_b=10, alu_op=00, so the branch/JAL target is latched into ALUOut. Dispatch on opcode:
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 0000011 or 0100011 → MEM_ADDR
  - 1100011 → BRANCH
  - 1101111 → JAL
  - anything else → HALT
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10, then WB_ALU.
- EXEC_I: alu_src_a=10, alu_src_b=10, alu_op=10, then WB_ALU.
- MEM_ADDR: alu_src_a=10, alu_src_b=10, alu_op=00. Go to MEM_RD if opcode is 0000011, otherwise MEM_WR.
- MEM_RD: mem_req=1, mem_we=0. Wait for mem_ready, then go to WB_MEM.
- MEM_WR: mem_req=1, mem_we=1. Wait for mem_ready, then go to FETCH.
- WB_ALU: rf_we=1, wb_sel=00, then FETCH.
- WB_MEM: rf_we=1, wb_sel=01, then FETCH.
- BRANCH:
  - alu_src_a=10, alu_src_b=00, alu_op=01.
  - funct3 000 (beq): taken when zero=1. funct3 001 (bne): taken when zero=0. Other funct3 → HALT.
  - If taken: pc_we=1, pc_src=1. Always then go to FETCH.
- JAL: rf_we=1, wb_sel=10 (the PC already holds PC+4), pc_we=1, pc_src=1, then FETCH.
- HALT: halted=1, all enables 0. Stays in HALT until reset.
- Output decode:
  - Outputs are combinational from state.
  - ir_we, pc_we and the branch-state PC write additionally depend on mem_ready, zero and funct3.
  - opcode is sampled only in DECODE and MEM_ADDR. The instruction register is stable from DECODE until the next FETCH completes.

## Timing
- Reset:
  - While rst=0: state=FETCH (0) and all enables are forced to 0, including mem_req.
  - halted=0.
  - Select outputs are 0 during reset.
- First cycle after rst rises: FETCH with mem_req=1.
- Memory handshake:
  - A request completes in the cycle where mem_req=1 and mem_ready=1.
  - mem_ready is ignored when mem_req=0.
  - mem_req, mem_we and the selects stay stable while waiting.
- Cycles per instruction with zero-wait memory (mem_ready=1 in the same cycle):
  - R/I ALU: 4
  - load: 5
  - store: 4
  - branch: 3
  - jal: 3
  - Each memory wait cycle adds 1.
- Reset asserted mid-request: mem_req drops immediately (asynchronous) and FETCH restarts after release. Memory tolerates abandoned requests.
- Simultaneous mem_ready and state change: the write enables for that cycle take effect at the same edge the state advances.

## Configuration
- POLIRISCV_MC_PERFCNT_EN defined: adds two output ports.
  - cycle_cnt (out, 32): +1 every clock while not reset and not halted.
  - instret_cnt (out, 32): +1 on every transition into FETCH from a non-FETCH state.
  - Both counters reset to 0 and wrap modulo 2^32.
- Not defined: both ports and counters are absent. Behaviour is otherwise identical.

## Test plan
- Reset, then add (0x00000033-class opcode) with mem_ready tied 1 → state sequence 0,1,2,7,0. rf_we=1 only in state 7. pc_we=1 only in cycle 1. instret_cnt=1 after 4 cycles.
- Load (opcode 0000011), mem_ready low for 3 cycles in MEM_RD → mem_req held 4 cycles with mem_we=0. WB_MEM asserts wb_sel=01. Total 8 cycles.
- beq with zero=1, then bne with zero=1 → first: pc_we=1, pc_src=1 in BRANCH. Second: pc_we=0. Both return to FETCH after 3 cycles.
- Store, mem_ready=1 → mem_we=1 in state 6 only. rf_we never asserted.
- Opcode 0x7F in DECODE → state 15, halted=1, all enables 0 for 20 cycles. cycle_cnt frozen. Asserting rst clears halted to 0.
- rst pulsed low during MEM_RD wait → mem_req=0 within the low phase. After release, state=0 and counters are 0.
